// File: rtl/sigmoid_table_loader_pkg.sv
// rtl/sigmoid_table_loader_pkg.sv - shared types and widths for the sigmoid table loader
//
// Purpose: holds the loader FSM state encoding and the data/address widths
// used by the loader and by the sigmoid register bank it feeds.

package sigmoid_table_loader_pkg;

  // Width of one sigmoid table value
  localparam int DATA_W = 4;

  // Width of the register-bank address (covers up to 32 entries)
  localparam int ADDR_W = 5;

  // Largest table the address space can hold
  localparam int MAX_ENTRIES = 1 << ADDR_W;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

endpackage : sigmoid_table_loader_pkg

// File: rtl/sigmoid_table_loader.sv
// rtl/sigmoid_table_loader.sv - streams sigmoid table values into the sigmoid register bank
//
// Purpose: on a start pulse, accepts NUM_ENTRIES values from an upstream
// valid/ready stream and writes each one, one cycle after acceptance, to
// consecutive addresses of the sigmoid register bank. A running XOR of the
// accepted values is kept as a checksum.
//
// Ports:
//   clk          rising-edge clock
//   n_rst        asynchronous active-low reset
//   start        single-cycle request to begin a load sequence (IDLE only)
//   in_valid     upstream value present
//   in_data      upstream table value (bit 0 is the MSB)
//   in_ready     loader accepts in_data this cycle (high throughout LOAD)
//   write_en     register-bank write strobe
//   address_out  register-bank address (bit 0 is the MSB)
//   data_out     register-bank write data
//   busy         sequence in progress, including the final write cycle
//   done         one-cycle pulse coincident with the final write
//   checksum     XOR of all values accepted in the current or last sequence

module sigmoid_table_loader
  import sigmoid_table_loader_pkg::*;
#(
  parameter int NUM_ENTRIES = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [0:DATA_W-1] in_data,
  output logic              in_ready,
  output logic              write_en,
  output logic [0:ADDR_W-1] address_out,
  output logic [0:DATA_W-1] data_out,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  // Address of the final entry; the counter stops here rather than wrapping
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ENTRIES - 1);

  state_t            state;
  logic [ADDR_W-1:0] counter;
  logic              accept;

  // Ready is a pure decode of the state register so upstream never sees a
  // combinational path from in_valid back to in_ready.
  assign in_ready = (state == LOAD);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      counter     <= '0;
      address_out <= '0;
      data_out    <= '0;
      checksum    <= '0;
      write_en    <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // Strobes default low; only an accepted beat raises write_en next cycle
      write_en <= accept;
      done     <= 1'b0;

      case (state)
        IDLE: begin
          busy <= 1'b0;
          // The done cycle is spent in IDLE; a start arriving then is dropped
          if (start && !done) begin
            state    <= LOAD;
            counter  <= '0;
            checksum <= '0;
            busy     <= 1'b1;
          end
        end

        LOAD: begin
          busy <= 1'b1;
          if (accept) begin
            address_out <= counter;
            data_out    <= in_data;
            checksum    <= checksum ^ in_data;
            if (counter == LAST_ADDR) begin
              // busy stays high for the cycle carrying the final write
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              counter <= counter + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule : sigmoid_table_loader

// File: tb/tb_sigmoid_table_loader.sv
// tb/tb_sigmoid_table_loader.sv - directed self-checking bench for sigmoid_table_loader

module tb_sigmoid_table_loader;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start;
  logic       in_valid;
  logic [0:3] in_data;
  logic       in_ready;
  logic       write_en;
  logic [0:4] address_out;
  logic [0:3] data_out;
  logic       busy;
  logic       done;
  logic [3:0] checksum;

  logic       start_m;
  logic       in_valid_m;
  logic [0:3] in_data_m;
  logic       in_ready_m;
  logic       write_en_m;
  logic [0:4] address_out_m;
  logic [0:3] data_out_m;
  logic       busy_m;
  logic       done_m;
  logic [3:0] checksum_m;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] csum;

  always #5 clk = ~clk;

  sigmoid_table_loader #(.NUM_ENTRIES(32)) u_dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .write_en   (write_en),
    .address_out(address_out),
    .data_out   (data_out),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  sigmoid_table_loader #(.NUM_ENTRIES(1)) u_min (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start_m),
    .in_valid   (in_valid_m),
    .in_data    (in_data_m),
    .in_ready   (in_ready_m),
    .write_en   (write_en_m),
    .address_out(address_out_m),
    .data_out   (data_out_m),
    .busy       (busy_m),
    .done       (done_m),
    .checksum   (checksum_m)
  );

  task automatic apply_reset();
    n_rst      = 1'b0;
    start      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    start_m    = 1'b0;
    in_valid_m = 1'b0;
    in_data_m  = '0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    n_rst      = 1'b0;
    start      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    start_m    = 1'b0;
    in_valid_m = 1'b0;
    in_data_m  = '0;
    @(negedge clk);
    checks++;
    if ({in_ready, write_en, address_out, data_out, busy, done, checksum} !== 17'h0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0",
               {in_ready, write_en, address_out, data_out, busy, done, checksum});
    end
    checks++;
    if ({in_ready_m, write_en_m, address_out_m, data_out_m, busy_m, done_m, checksum_m} !== 17'h0) begin
      errors++;
      $display("FAIL reset_state_min: got %h expected 0",
               {in_ready_m, write_en_m, address_out_m, data_out_m, busy_m, done_m, checksum_m});
    end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_load();
    pulse_start();
    checks++;
    if ({busy, in_ready} !== 2'b11) begin
      errors++;
      $display("FAIL start_enters_load: got busy/in_ready=%b expected 11", {busy, in_ready});
    end
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i % 16);
      @(negedge clk);
      checks++;
      if ({write_en, address_out, data_out, done, busy} !==
          {1'b1, 5'(i), 4'(i % 16), 1'(i == 31), 1'b1}) begin
        errors++;
        $display("FAIL full_load_beat%0d: got we/addr/data/done/busy=%h expected %h", i,
                 {write_en, address_out, data_out, done, busy},
                 {1'b1, 5'(i), 4'(i % 16), 1'(i == 31), 1'b1});
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({write_en, done, busy, in_ready, address_out, checksum} !== {4'b0000, 5'd31, 4'h0}) begin
      errors++;
      $display("FAIL full_load_end: got we/done/busy/rdy/addr/csum=%h expected %h",
               {write_en, done, busy, in_ready, address_out, checksum}, {4'b0000, 5'd31, 4'h0});
    end
  endtask

  task automatic test_ignored_start();
    pulse_start();
    csum = 4'h0;
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      in_data  = 4'((i * 7 + 3) % 16);
      start    = (i == 10);
      csum     = csum ^ 4'((i * 7 + 3) % 16);
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({write_en, address_out, data_out, done} !== {1'b1, 5'(i), 4'((i * 7 + 3) % 16), 1'(i == 31)}) begin
        errors++;
        $display("FAIL ignored_start_beat%0d: got we/addr/data/done=%h expected %h", i,
                 {write_en, address_out, data_out, done},
                 {1'b1, 5'(i), 4'((i * 7 + 3) % 16), 1'(i == 31)});
      end
    end
    // start raised during the done cycle must not launch a new sequence
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, in_ready, write_en, checksum} !== {3'b000, csum}) begin
      errors++;
      $display("FAIL start_in_done_cycle: got busy/rdy/we/csum=%h expected %h",
               {busy, in_ready, write_en, checksum}, {3'b000, csum});
    end
  endtask

  task automatic test_idle_input();
    in_valid = 1'b1;
    in_data  = 4'h7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, write_en, busy, checksum} !== {3'b000, csum}) begin
        errors++;
        $display("FAIL idle_input_%0d: got rdy/we/busy/csum=%h expected %h", k,
                 {in_ready, write_en, busy, checksum}, {3'b000, csum});
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic       v [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] d [4] = '{4'h3, 4'h9, 4'h9, 4'h5};
    logic [4:0] exp_a;
    logic [3:0] exp_d;
    int         nacc;
    nacc  = 0;
    exp_a = '0;
    exp_d = '0;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      in_valid = v[k];
      in_data  = d[k];
      @(negedge clk);
      if (v[k]) begin
        exp_a = 5'(nacc);
        exp_d = d[k];
        nacc++;
      end
      checks++;
      if ({write_en, address_out, data_out, busy} !== {v[k], exp_a, exp_d, 1'b1}) begin
        errors++;
        $display("FAIL stall_step%0d: got we/addr/data/busy=%h expected %h", k,
                 {write_en, address_out, data_out, busy}, {v[k], exp_a, exp_d, 1'b1});
      end
    end
    in_valid = 1'b0;
    apply_reset();
  endtask

  task automatic test_reset_mid();
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i + 1);
      @(negedge clk);
    end
    checks++;
    if ({write_en, address_out, checksum} !== {1'b1, 5'd4, 4'h1}) begin
      errors++;
      $display("FAIL pre_reset_state: got we/addr/csum=%h expected %h",
               {write_en, address_out, checksum}, {1'b1, 5'd4, 4'h1});
    end
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if ({write_en, address_out, checksum, busy, done, in_ready} !== 14'h0) begin
      errors++;
      $display("FAIL async_reset_mid: got we/addr/csum/busy/done/rdy=%h expected 0",
               {write_en, address_out, checksum, busy, done, in_ready});
    end
    @(negedge clk);
    n_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({write_en, in_ready, busy} !== 3'b000) begin
        errors++;
        $display("FAIL no_write_after_reset_%0d: got we/rdy/busy=%b expected 000", k,
                 {write_en, in_ready, busy});
      end
    end
    in_valid = 1'b0;
    pulse_start();
    in_valid = 1'b1;
    in_data  = 4'h6;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({write_en, address_out, data_out, checksum} !== {1'b1, 5'd0, 4'h6, 4'h6}) begin
      errors++;
      $display("FAIL restart_after_reset: got we/addr/data/csum=%h expected %h",
               {write_en, address_out, data_out, checksum}, {1'b1, 5'd0, 4'h6, 4'h6});
    end
    apply_reset();
  endtask

  task automatic test_min_table();
    start_m = 1'b1;
    @(negedge clk);
    start_m    = 1'b0;
    in_valid_m = 1'b1;
    in_data_m  = 4'hA;
    @(negedge clk);
    in_valid_m = 1'b0;
    checks++;
    if ({write_en_m, address_out_m, data_out_m, done_m, busy_m, checksum_m} !==
        {1'b1, 5'd0, 4'hA, 1'b1, 1'b1, 4'hA}) begin
      errors++;
      $display("FAIL min_table_write: got we/addr/data/done/busy/csum=%h expected %h",
               {write_en_m, address_out_m, data_out_m, done_m, busy_m, checksum_m},
               {1'b1, 5'd0, 4'hA, 1'b1, 1'b1, 4'hA});
    end
    @(negedge clk);
    checks++;
    if ({write_en_m, done_m, busy_m, in_ready_m, checksum_m} !== {4'b0000, 4'hA}) begin
      errors++;
      $display("FAIL min_table_after: got we/done/busy/rdy/csum=%h expected %h",
               {write_en_m, done_m, busy_m, in_ready_m, checksum_m}, {4'b0000, 4'hA});
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_ignored_start();
    test_idle_input();
    test_stall();
    test_reset_mid();
    test_min_table();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule : tb_sigmoid_table_loader

// File: doc/sigmoid_table_loader.md
SIGMOID_TABLE_LOADER -- requirements
Module: sigmoid_table_loader

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 32, meaning the number of sigmoid table entries loaded per sequence (legal range 1..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: single-cycle request to begin a load sequence.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream table value present.
REQ-006 SHALL have port in_data, input, 4 bits: upstream sigmoid table value; bit 0 is the MSB.
REQ-007 SHALL have port in_ready, output, 1 bit: the loader accepts in_data this cycle.
REQ-008 SHALL have port write_en, output, 1 bit: write strobe to the sigmoid register bank.
REQ-009 SHALL have port address_out, output, 5 bits: register-bank address; bit 0 is the MSB.
REQ-010 SHALL have port data_out, output, 4 bits: register-bank write data.
REQ-011 SHALL have port busy, output, 1 bit: a load sequence is in progress.
REQ-012 SHALL have port done, output, 1 bit: single-cycle pulse marking completion of the sequence.
REQ-013 SHALL have port checksum, output, 4 bits: XOR of all values accepted in the current or last sequence.

Function
REQ-014 SHALL implement FSM states IDLE and LOAD.
REQ-015 IDLE -> LOAD SHALL occur on start=1; this transition clears the entry counter and checksum to 0.
REQ-016 in_ready SHALL be 1 exactly when the state is LOAD, as a combinational decode of the state register only.
REQ-017 A beat SHALL be accepted only when in_valid=1 and in_ready=1 in the same cycle; otherwise nothing changes.
REQ-018 For a beat accepted at cycle t, write_en SHALL be 1 at t+1 with address_out = counter value at t and data_out = in_data at t. Write latency is 1 cycle.
REQ-019 write_en, address_out and data_out SHALL be registered outputs; write_en is 0 in any cycle that does not follow an accepted beat.
REQ-020 address_out and data_out SHALL hold their last values while write_en=0.
REQ-021 The counter SHALL increment by 1 per accepted beat.
REQ-022 When the beat accepted has counter = NUM_ENTRIES-1, the state SHALL return to IDLE at t+1; done=1 at t+1, coincident with the final write_en.
REQ-023 checksum SHALL update to checksum XOR in_data on each accepted beat, and hold its value after done.
REQ-024 busy SHALL be 1 in LOAD and in the cycle carrying the final write_en; otherwise 0.
REQ-025 start while in LOAD, or in the done cycle, SHALL be ignored.
REQ-026 Gaps in in_valid SHALL stall the sequence indefinitely without timeout.
REQ-027 The counter SHALL never exceed NUM_ENTRIES-1, so address_out never wraps past the table.

Reset
REQ-028 On n_rst=0, asynchronously: state = IDLE; counter, address_out, data_out and checksum = 0; write_en, done and busy = 0.
REQ-029 Reset asserted mid-sequence SHALL abandon the sequence with no further write_en; a new start is required after release.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the data width constant (4) and the address width constant (5).
REQ-031 The downstream consumer SHALL be the existing bank of addressable sigmoid registers, driven directly by write_en, address_out and data_out.
REQ-032 No sub-module is required; the counter and FSM SHALL reside in this module.

Verification
REQ-033 Reset scenario: reset mid-sequence after 5 beats -> write_en=0, address_out=0 and checksum=0 immediately; no writes until the next start.
REQ-034 Full load scenario: NUM_ENTRIES=32, start, then 32 back-to-back beats with in_data = index mod 16 -> 32 write_en pulses at addresses 0..31, each 1 cycle after acceptance; done on the 32nd pulse; checksum = 0.
REQ-035 Stall scenario: in_valid toggling 1,0,0,1 -> write_en only after accepted beats; address_out holds across gaps.
REQ-036 Ignored start scenario: start pulsed at beat 10 -> counter is not cleared; remaining addresses continue 10..31.
REQ-037 Minimum table scenario: NUM_ENTRIES=1, start, one beat with value 0xA -> a single write to address 0 with data 0xA; done and busy high in the same cycle; checksum = 0xA.
REQ-038 Idle input scenario: in_valid=1 while IDLE -> in_ready=0, no write_en, checksum unchanged.
